// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous content commit.
// Optional SEG7_BRIGHTNESS_PWM_EN adds a 4-bit per-slot PWM brightness input.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 32768
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    LOAD_VALID,
  output logic                    LOAD_READY,
  input  logic [4*NUM_DIGITS-1:0] DATA_IN,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic [NUM_DIGITS-1:0]   BLANK_IN,
  input  logic                    LZ_SUPPRESS,
`ifdef SEG7_BRIGHTNESS_PWM_EN
  input  logic [3:0]              BRIGHTNESS,
`endif
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              SEG,
  output logic                    FRAME_DONE
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [DW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic          tick;
  logic          frame_end;
  logic          accept;

  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;

  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   disp_blank;

  logic [IW-1:0] hi;
  logic [3:0]    nib;
  logic          dp_bit;
  logic          bl_bit;
  logic          lit;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0001100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b1110010;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign tick       = (div_cnt == DIV_LAST);
  assign frame_end  = tick && (idx == IDX_LAST);
  assign LOAD_READY = ~pend_valid & ~RESET;
  assign accept     = LOAD_VALID & LOAD_READY;

  always_comb begin
    hi     = '0;
    nib    = '0;
    dp_bit = 1'b0;
    bl_bit = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_data[4*i +: 4] != 4'h0) hi = IW'(i);
      if (IW'(i) == idx) begin
        nib    = disp_data[4*i +: 4];
        dp_bit = disp_dp[i];
        bl_bit = disp_blank[i];
      end
    end
    // digit 0 can never exceed hi, so it always survives suppression
    lit = ~bl_bit && !(LZ_SUPPRESS && (idx > hi));
`ifdef SEG7_BRIGHTNESS_PWM_EN
    lit = lit && (div_cnt[DW-1 -: 4] <= BRIGHTNESS);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt    <= '0;
      idx        <= '0;
      FRAME_DONE <= 1'b0;
      AN         <= '1;
      SEG        <= 8'hFF;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + DW'(1);
      FRAME_DONE <= frame_end;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      AN  <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      SEG <= lit ? {glyph(nib), ~dp_bit} : 8'hFF;
    end
  end

  // commit and accept are exclusive: one needs pend_valid set, the other clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blank <= '1;
    end else if (frame_end && pend_valid) begin
      pend_valid <= 1'b0;
      disp_data  <= pend_data;
      disp_dp    <= pend_dp;
      disp_blank <= pend_blank;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_data  <= DATA_IN;
      pend_dp    <= DP_IN;
      pend_blank <= BLANK_IN;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 16 clocks per slot).
// Inputs change and outputs are sampled on the falling edge.
module tb_seg7_scan_driver;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        LOAD_VALID;
  logic        LOAD_READY;
  logic [15:0] DATA_IN;
  logic [3:0]  DP_IN;
  logic [3:0]  BLANK_IN;
  logic        LZ_SUPPRESS;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic        FRAME_DONE;
`ifdef SEG7_BRIGHTNESS_PWM_EN
  logic [3:0]  BRIGHTNESS = 4'hF;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(16)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .LOAD_VALID(LOAD_VALID),
    .LOAD_READY(LOAD_READY),
    .DATA_IN(DATA_IN),
    .DP_IN(DP_IN),
    .BLANK_IN(BLANK_IN),
    .LZ_SUPPRESS(LZ_SUPPRESS),
`ifdef SEG7_BRIGHTNESS_PWM_EN
    .BRIGHTNESS(BRIGHTNESS),
`endif
    .AN(AN),
    .SEG(SEG),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic dig(input string tag, input logic [3:0] an,
                     input logic [7:0] seg);
    chk({tag, ".an"}, 32'(AN), 32'(an));
    chk({tag, ".seg"}, 32'(SEG), 32'(seg));
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] bl);
    LOAD_VALID = 1'b1;
    DATA_IN    = d;
    DP_IN      = dp;
    BLANK_IN   = bl;
  endtask

  initial begin
    RESET       = 1'b1;
    LOAD_VALID  = 1'b0;
    DATA_IN     = '0;
    DP_IN       = '0;
    BLANK_IN    = '0;
    LZ_SUPPRESS = 1'b0;
    repeat (3) @(negedge CLK);
    dig("rst", 4'hF, 8'hFF);
    chk("rst.fd", 32'(FRAME_DONE), 0);
    chk("rst.rdy", 32'(LOAD_READY), 0);
    RESET = 1'b0;
    cyc = 0;

    // idle: dark, ready, frame pulse every 64 cycles
    for (int n = 1; n <= 200; n++) begin
      goto(n);
      dig("idle", 4'hF, 8'hFF);
      chk("idle.rdy", 32'(LOAD_READY), 1);
      chk("idle.fd", 32'(FRAME_DONE), 32'((n % 64) == 0));
    end

    // 12AF with dp on digit 2; commit at 256
    offer(16'h12AF, 4'b0100, 4'b0000);
    goto(201);
    LOAD_VALID = 1'b0;
    goto(202);
    chk("ld1.rdy_lo", 32'(LOAD_READY), 0);
    goto(255);
    chk("ld1.rdy_pre", 32'(LOAD_READY), 0);
    goto(256);
    chk("ld1.rdy_post", 32'(LOAD_READY), 1);
    dig("ld1.old", 4'hF, 8'hFF);
    goto(257);
    dig("ld1.s0_first", 4'b1110, 8'b0111000_1);
    goto(264);
    dig("ld1.s0", 4'b1110, 8'b0111000_1);
    goto(280);
    dig("ld1.s1", 4'b1101, 8'b0001000_1);
    goto(296);
    dig("ld1.s2", 4'b1011, 8'b0010010_0);
    goto(312);
    dig("ld1.s3", 4'b0111, 8'b1001111_1);

    // leading-zero suppression; commit at 384
    goto(330);
    LZ_SUPPRESS = 1'b1;
    offer(16'h0050, 4'b0000, 4'b0000);
    goto(331);
    LOAD_VALID = 1'b0;
    goto(392);
    dig("lz.s0", 4'b1110, 8'b0000001_1);
    goto(408);
    dig("lz.s1", 4'b1101, 8'b0100100_1);
    goto(424);
    dig("lz.s2", 4'hF, 8'hFF);
    goto(440);
    dig("lz.s3", 4'hF, 8'hFF);

    // all zero: only digit 0 lit; commit at 512
    goto(460);
    offer(16'h0000, 4'b0000, 4'b0000);
    goto(461);
    LOAD_VALID = 1'b0;
    goto(520);
    dig("z.s0", 4'b1110, 8'b0000001_1);
    goto(536);
    dig("z.s1", 4'hF, 8'hFF);
    goto(552);
    dig("z.s2", 4'hF, 8'hFF);
    goto(568);
    dig("z.s3", 4'hF, 8'hFF);

    // back-to-back offers: A commits at 640, B accepted at 641, commits at 704
    goto(580);
    offer(16'h3456, 4'b0000, 4'b0000);
    goto(581);
    chk("bb.rdy_a", 32'(LOAD_READY), 0);
    offer(16'h789C, 4'b1000, 4'b0010);
    goto(620);
    chk("bb.rdy_mid", 32'(LOAD_READY), 0);
    goto(639);
    chk("bb.rdy_pre", 32'(LOAD_READY), 0);
    goto(640);
    chk("bb.rdy_free", 32'(LOAD_READY), 1);
    chk("bb.fd", 32'(FRAME_DONE), 1);
    goto(641);
    chk("bb.rdy_b", 32'(LOAD_READY), 0);
    LOAD_VALID = 1'b0;
    goto(648);
    dig("bb.a0", 4'b1110, 8'b0100000_1);
    goto(664);
    dig("bb.a1", 4'b1101, 8'b0100100_1);
    goto(680);
    dig("bb.a2", 4'b1011, 8'b1001100_1);
    goto(696);
    dig("bb.a3", 4'b0111, 8'b0000110_1);
    goto(712);
    dig("bb.b0", 4'b1110, 8'b1110010_1);
    goto(728);
    dig("bb.b1", 4'hF, 8'hFF);
    goto(744);
    dig("bb.b2", 4'b1011, 8'b0000000_1);
    goto(760);
    dig("bb.b3", 4'b0111, 8'b0001111_0);

    // reset with data pending: dark, pending value discarded
    goto(775);
    offer(16'hDEAD, 4'b1111, 4'b0000);
    goto(776);
    LOAD_VALID = 1'b0;
    chk("rp.pend", 32'(LOAD_READY), 0);
    goto(778);
    RESET = 1'b1;
    goto(779);
    dig("rp.rst", 4'hF, 8'hFF);
    chk("rp.rdy", 32'(LOAD_READY), 0);
    chk("rp.fd", 32'(FRAME_DONE), 0);
    RESET = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 80; n++) begin
      goto(n);
      dig("rp.dark", 4'hF, 8'hFF);
      chk("rp.fd_t", 32'(FRAME_DONE), 32'(n == 64));
    end
    chk("rp.rdy_after", 32'(LOAD_READY), 1);

`ifdef SEG7_BRIGHTNESS_PWM_EN
    begin
      int on;
      offer(16'h1111, 4'b0000, 4'b0000);
      goto(81);
      LOAD_VALID = 1'b0;
      goto(130);
      BRIGHTNESS = 4'd3;
      on = 0;
      for (int n = 145; n <= 160; n++) begin
        goto(n);
        if (AN != 4'hF) on++;
      end
      chk("pwm.b3", 32'(on), 4);
      BRIGHTNESS = 4'd15;
      on = 0;
      for (int n = 161; n <= 176; n++) begin
        goto(n);
        if (AN != 4'hF) on++;
      end
      chk("pwm.b15", 32'(on), 16);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
